// File: rtl/game_control_if.sv
// Handshake bundle between the game FSM and the datapath/keys.
// master = FSM side, slave = datapath/stimulus side.
interface game_control_if;
  logic       go;
  logic       win;
  logic       lose;
  logic       datapath_reset;
  logic       datapath_start;
  logic       datapath_target;
  logic       datapath_load_angle;
  logic       datapath_wait;
  logic       datapath_load_strength;
  logic       datapath_draw;
  logic       datapath_win;
  logic       datapath_lose;
  logic [2:0] lives_left;
  logic [3:0] state_out;

  modport master (
    input  go, win, lose,
    output datapath_reset, datapath_start,
    output datapath_target, datapath_load_angle,
    output datapath_wait, datapath_load_strength,
    output datapath_draw, datapath_win,
    output datapath_lose, lives_left, state_out
  );

  modport slave (
    output go, win, lose,
    input  datapath_reset, datapath_start,
    input  datapath_target, datapath_load_angle,
    input  datapath_wait, datapath_load_strength,
    input  datapath_draw, datapath_win,
    input  datapath_lose, lives_left, state_out
  );
endinterface

// File: rtl/game_control.sv
// Game phase sequencer: key-driven and timed phases,
// one-hot datapath strobes and a lives counter.
module game_control #(
  parameter int FILL_CYCLES   = 19200,
  parameter int TARGET_CYCLES = 65,
  parameter int DRAW_TIMEOUT  = 40000,
  parameter int LIVES         = 3
) (
  input  logic          clk,
  input  logic          reset,
  game_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FRONT    = 4'd0,
    S_START    = 4'd1,
    S_TARGET   = 4'd2,
    S_ANGLE    = 4'd3,
    S_WAIT     = 4'd4,
    S_STRENGTH = 4'd5,
    S_DRAW     = 4'd6,
    S_WIN      = 4'd7,
    S_LOSE     = 4'd8
  } state_t;

  localparam logic [15:0] FILL_C = 16'(FILL_CYCLES);
  localparam logic [15:0] TGT_C  = 16'(TARGET_CYCLES);
  localparam logic [15:0] TO_C   = 16'(DRAW_TIMEOUT);
  localparam logic [2:0]  LIV_C  = 3'(LIVES);

  state_t      state;
  state_t      nxt;
  logic [15:0] cnt;
  logic [2:0]  lives;
  logic [8:0]  strobe;
  logic        sync0;
  logic        sync1;
  logic        prev;
  logic        go_pulse;
  logic        filled;

  assign go_pulse = sync1 & ~prev;
  assign filled   = cnt >= FILL_C;

  always_comb begin
    nxt = state;
    unique case (state)
      S_FRONT:    if (filled && go_pulse) nxt = S_START;
      S_START:    if (cnt == FILL_C - 16'd1) nxt = S_TARGET;
      S_TARGET:   if (cnt == TGT_C - 16'd1) nxt = S_ANGLE;
      S_ANGLE:    if (go_pulse) nxt = S_WAIT;
      S_WAIT:     if (cnt == 16'd1) nxt = S_STRENGTH;
      S_STRENGTH: if (go_pulse) nxt = S_DRAW;
      S_DRAW: begin
        if (bus.win) nxt = S_WIN;
        else if (bus.lose || cnt == TO_C - 16'd1)
          nxt = S_LOSE;
      end
      S_WIN:      if (filled && go_pulse) nxt = S_START;
      S_LOSE: begin
        if (filled && go_pulse)
          nxt = (lives == 3'd0) ? S_FRONT : S_START;
      end
      default:    nxt = S_FRONT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_FRONT;
      cnt    <= '0;
      lives  <= LIV_C;
      strobe <= 9'd1;
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync0 <= bus.go;
      sync1 <= sync0;
      prev  <= sync1;
      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      if (state == S_FRONT && nxt == S_START)
        lives <= LIV_C;
      else if (state == S_DRAW && nxt == S_LOSE
               && lives != 3'd0)
        lives <= lives - 3'd1;
      // nxt is always a legal code, so this stays one-hot
      strobe <= 9'd1 << nxt;
    end
  end

  assign bus.datapath_reset         = strobe[0];
  assign bus.datapath_start         = strobe[1];
  assign bus.datapath_target        = strobe[2];
  assign bus.datapath_load_angle    = strobe[3];
  assign bus.datapath_wait          = strobe[4];
  assign bus.datapath_load_strength = strobe[5];
  assign bus.datapath_draw          = strobe[6];
  assign bus.datapath_win           = strobe[7];
  assign bus.datapath_lose          = strobe[8];
  assign bus.lives_left             = lives;
  assign bus.state_out              = state;

endmodule

// File: tb/tb_game_control.sv
// Scoreboard bench for game_control with shortened
// paint/target/timeout lengths.
module tb_game_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string tag;
    int    st;
    int    lv;
  } exp_t;
  exp_t sbq[$];

  game_control_if bus();

  game_control #(
    .FILL_CYCLES(16),
    .TARGET_CYCLES(5),
    .DRAW_TIMEOUT(20),
    .LIVES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic push(string tag, int st, int lv);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.lv  = lv;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [8:0] strb;
    logic [8:0] want;
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    strb = {bus.datapath_lose, bus.datapath_win,
            bus.datapath_draw, bus.datapath_load_strength,
            bus.datapath_wait, bus.datapath_load_angle,
            bus.datapath_target, bus.datapath_start,
            bus.datapath_reset};
    want = 9'd1 << e.st;
    chk({e.tag, ".state"}, int'(bus.state_out), e.st);
    chk({e.tag, ".lives"}, int'(bus.lives_left), e.lv);
    chk({e.tag, ".strobe"}, int'(strb), int'(want));
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // expectation queued as stimulus time advances
  task automatic step(int n, string tag, int st, int lv);
    push(tag, st, lv);
    tick(n);
    pop_check();
  endtask

  task automatic to_draw(int lv);
    bus.go = 1'b1;
    step(3, "ang_go", 4, lv);
    bus.go = 1'b0;
    step(2, "wait2", 5, lv);
    bus.go = 1'b1;
    step(3, "str_go", 6, lv);
    bus.go = 1'b0;
  endtask

  initial begin
    bus.go = 1'b0;
    bus.win = 1'b0;
    bus.lose = 1'b0;
    tick(2);
    push("in_reset", 0, 2);
    pop_check();
    @(posedge clk);
    #2 reset = 1'b0;
    tick(1);
    // early key during front paint
    bus.go = 1'b1;
    step(4, "front_early", 0, 2);
    bus.go = 1'b0;
    step(16, "front_fill", 0, 2);
    bus.go = 1'b1;
    step(2, "front_lat2", 0, 2);
    step(1, "front_go", 1, 2);
    step(15, "start_hold", 1, 2);
    bus.go = 1'b0;
    step(1, "to_target", 2, 2);
    step(4, "target_hold", 2, 2);
    step(1, "to_angle", 3, 2);
    step(30, "angle_idle", 3, 2);
    // held key: single transition only
    bus.go = 1'b1;
    step(2, "ang_lat", 3, 2);
    step(1, "to_wait", 4, 2);
    step(1, "wait1", 4, 2);
    step(1, "to_str", 5, 2);
    step(45, "str_held", 5, 2);
    bus.go = 1'b0;
    step(3, "str_rel", 5, 2);
    bus.go = 1'b1;
    step(3, "to_draw", 6, 2);
    bus.go = 1'b0;
    bus.win = 1'b1;
    bus.lose = 1'b1;
    step(1, "win_prio", 7, 2);
    bus.win = 1'b0;
    bus.lose = 1'b0;
    bus.go = 1'b1;
    step(4, "win_early", 7, 2);
    bus.go = 1'b0;
    step(14, "win_fill", 7, 2);
    bus.go = 1'b1;
    step(3, "win_go", 1, 2);
    bus.go = 1'b0;
    step(21, "r1_angle", 3, 2);
    to_draw(2);
    step(19, "r1_draw", 6, 2);
    step(1, "r1_timeout", 8, 1);
    step(16, "r1_fill", 8, 1);
    bus.go = 1'b1;
    step(3, "r1_restart", 1, 1);
    bus.go = 1'b0;
    step(21, "r2_angle", 3, 1);
    bus.win = 1'b1;
    step(2, "stale_win", 3, 1);
    bus.win = 1'b0;
    to_draw(1);
    step(20, "r2_timeout", 8, 0);
    step(16, "r2_fill", 8, 0);
    bus.go = 1'b1;
    step(3, "game_over", 0, 0);
    bus.go = 1'b0;
    step(16, "front2", 0, 0);
    bus.go = 1'b1;
    step(3, "new_game", 1, 2);
    bus.go = 1'b0;
    step(21, "r3_angle", 3, 2);
    to_draw(2);
    bus.lose = 1'b1;
    step(1, "lose_flag", 8, 1);
    bus.lose = 1'b0;
    step(16, "r3_fill", 8, 1);
    bus.go = 1'b1;
    step(3, "r3_restart", 1, 1);
    bus.go = 1'b0;
    step(21, "r4_angle", 3, 1);
    to_draw(1);
    step(5, "r4_draw", 6, 1);
    // async reset between edges
    #3 reset = 1'b1;
    #1;
    push("async_rst", 0, 2);
    pop_check();
    tick(2);
    #2 reset = 1'b0;
    step(3, "post_rst", 0, 2);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
